// File: rtl/imm_gen_stage_if.sv
// rtl/imm_gen_stage_if.sv - handshake bundle between the decode feed, imm_gen_stage and its consumer
//
// Purpose: groups the input (instruction side) and output (immediate side)
// valid/ready channels of imm_gen_stage.
// Signals:
//   in_valid, in_ready, in_instr[31:0], in_imm_type[3:0], in_tag[TAG_W-1:0]
//   out_valid, out_ready, out_imm[XLEN-1:0], out_tag[TAG_W-1:0], out_illegal
// Modports:
//   slave  - the immediate generator (consumes instructions, produces immediates)
//   master - the environment (drives instructions, accepts immediates)
interface imm_gen_stage_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [3:0]       in_imm_type;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_instr, in_imm_type, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_imm_type, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// rtl/imm_gen_stage.sv - registered immediate generator with a 2-entry skid buffer
//
// Purpose: decodes the immediate of a 32-bit (or RVC 16-bit) instruction,
// extends it to XLEN and delivers it with its tag one cycle after acceptance.
// Optional feature macro: RVC_EN (enables codes 8-12, compressed immediates).
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, clears all entries
//   flush - synchronous discard of all buffered entries and of the current input
//   bus   - imm_gen_stage_if.slave: in_* instruction channel, out_* immediate channel
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  imm_gen_stage_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  state_t      state_q, state_d;
  entry_t      main_q, skid_q, new_entry;
  logic        main_load, main_from_skid, skid_load;
  logic        accept, deliver;
  logic [31:0] instr;
  logic [63:0] ext64;
  logic        ill;
  logic        unused_bits;

  assign instr = bus.in_instr;

  // Everything is built 64 bits wide, sign-extended from its top bit, then
  // truncated; this gives correct XLEN=32 and XLEN=64 results from one table.
  always_comb begin
    ext64 = '0;
    ill   = 1'b0;
    case (bus.in_imm_type)
      4'd0: ext64 = '0;
      4'd1: ext64 = (XLEN == 64) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      4'd2: ext64 = {{52{instr[31]}}, instr[31:20]};
      4'd3: ext64 = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      4'd4: ext64 = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      4'd5: ext64 = {{32{instr[31]}}, instr[31:12], 12'b0};
      4'd6: ext64 = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      4'd7: ext64 = {59'b0, instr[19:15]};
`ifdef RVC_EN
      4'd8:  ext64 = {{58{instr[12]}}, instr[12], instr[6:2]};
      4'd9:  ext64 = {54'b0, instr[10:7], instr[12:11], instr[5], instr[6], 2'b0};
      4'd10: ext64 = {57'b0, instr[5], instr[12:10], instr[6], 2'b0};
      4'd11: ext64 = {{52{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                      instr[7], instr[2], instr[11], instr[5:3], 1'b0};
      4'd12: ext64 = {{55{instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                      instr[4:3], 1'b0};
`endif
      default: begin
        ext64 = '0;
        ill   = 1'b1;
      end
    endcase
  end

  // Opcode bits and the upper half of ext64 (XLEN=32) carry no immediate data.
  assign unused_bits = ^{ext64, instr[6:0]};

  assign new_entry.imm = ext64[XLEN-1:0];
  assign new_entry.tag = bus.in_tag;
  assign new_entry.ill = ill;

  // in_ready is a pure decode of the state register, so out_ready never
  // reaches it combinationally.
  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_imm     = main_q.imm;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.ill;

  assign accept  = bus.in_valid & bus.in_ready;
  assign deliver = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          // Accept with deliver refills main directly; the skid stays empty.
          if (accept && deliver) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_load) begin
        main_q <= main_from_skid ? skid_q : new_entry;
      end
      if (skid_load) begin
        skid_q <= new_entry;
      end
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb/tb_imm_gen_stage.sv - directed-vector bench for imm_gen_stage (XLEN=32)
module tb_imm_gen_stage;

  localparam int XLEN  = 32;
  localparam int TAG_W = 8;

  logic clk;
  logic reset;
  logic flush;
  int   n_total;
  int   n_pass;

  imm_gen_stage_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  imm_gen_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts just after a posedge with the buffer empty and out_ready=1.
  task automatic xfer(input string name, input logic [31:0] instr, input logic [3:0] ty,
                      input logic [7:0] tag, input logic [31:0] exp_imm, input logic exp_ill);
    bus.in_valid    = 1'b1;
    bus.in_instr    = instr;
    bus.in_imm_type = ty;
    bus.in_tag      = tag;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({name, ".valid"}, 64'(bus.out_valid), 64'd1);
    check({name, ".imm"}, 64'(bus.out_imm), 64'(exp_imm));
    check({name, ".tag"}, 64'(bus.out_tag), 64'(tag));
    check({name, ".ill"}, 64'(bus.out_illegal), 64'(exp_ill));
    @(posedge clk);
    #1;
  endtask

  // Loads two entries with out_ready=0, leaving the buffer FULL.
  task automatic fill_full(input logic [7:0] t0);
    bus.out_ready   = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_instr    = 32'h00100093;
    bus.in_imm_type = 4'd2;
    bus.in_tag      = t0;
    @(posedge clk);
    #1;
    bus.in_tag = t0 + 8'd1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int next_tag;
    int exp_tag;
    int got_cnt;
    int seen;
    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_imm_type = '0;
    bus.in_tag      = '0;
    bus.out_ready   = 1'b1;
    #1;
    check("rst.out_valid", 64'(bus.out_valid), 64'd0);
    check("rst.in_ready", 64'(bus.in_ready), 64'd1);
    check("rst.out_imm", 64'(bus.out_imm), 64'd0);
    check("rst.out_tag", 64'(bus.out_tag), 64'd0);
    check("rst.out_ill", 64'(bus.out_illegal), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    xfer("itype",   32'hFFF00093, 4'd2, 8'h11, 32'hFFFFFFFF, 1'b0);
    xfer("btype",   32'hFE000EE3, 4'd4, 8'h12, 32'hFFFFFFFC, 1'b0);
    xfer("none",    32'hFFFFFFFF, 4'd0, 8'h13, 32'h00000000, 1'b0);
    xfer("shamt",   32'h03F00013, 4'd1, 8'h14, 32'h0000001F, 1'b0);
    xfer("stype",   32'hFE112E23, 4'd3, 8'h15, 32'hFFFFFFFC, 1'b0);
    xfer("utype",   32'h12345037, 4'd5, 8'h16, 32'h12345000, 1'b0);
    xfer("utype_n", 32'h80000037, 4'd5, 8'h17, 32'h80000000, 1'b0);
    xfer("jtype",   32'hFF9FF06F, 4'd6, 8'h18, 32'hFFFFFFF8, 1'b0);
    xfer("zimm",    32'h800F8073, 4'd7, 8'h19, 32'h0000001F, 1'b0);
    xfer("rsvd14",  32'hFFFFFFFF, 4'd14, 8'h1A, 32'h00000000, 1'b1);
`ifdef RVC_EN
    xfer("rvc_ci",  32'h000010FD, 4'd8, 8'h1B, 32'hFFFFFFFF, 1'b0);
`else
    xfer("rvc_ci",  32'h000010FD, 4'd8, 8'h1B, 32'h00000000, 1'b1);
`endif

    // Stream tags 1..4 with out_ready low for the first three cycles.
    bus.out_ready   = 1'b0;
    bus.in_instr    = 32'h00500093;
    bus.in_imm_type = 4'd2;
    next_tag = 1;
    exp_tag  = 1;
    got_cnt  = 0;
    bus.in_valid = 1'b1;
    bus.in_tag   = 8'(next_tag);
    for (int cyc = 0; cyc < 30; cyc++) begin
      logic acc;
      @(negedge clk);
      if (cyc == 2) begin
        check("stream.in_ready_full", 64'(bus.in_ready), 64'd0);
        check("stream.hold_tag", 64'(bus.out_tag), 64'd1);
      end
      acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid && bus.out_ready) begin
        check("stream.order", 64'(bus.out_tag), 64'(exp_tag));
        check("stream.imm", 64'(bus.out_imm), 64'd5);
        exp_tag++;
        got_cnt++;
      end
      @(posedge clk);
      #1;
      if (cyc == 2) bus.out_ready = 1'b1;
      if (acc) begin
        next_tag++;
        if (next_tag > 4) bus.in_valid = 1'b0;
        else bus.in_tag = 8'(next_tag);
      end
    end
    check("stream.count", 64'(got_cnt), 64'd4);

    // Flush while FULL, with a fresh input presented in the same cycle.
    fill_full(8'h40);
    flush           = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_tag      = 8'h42;
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush.out_valid", 64'(bus.out_valid), 64'd0);
    check("flush.in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("flush.no_output", 64'(seen), 64'd0);
    @(posedge clk);
    #1;
    xfer("post_flush", 32'h80000037, 4'd5, 8'h43, 32'h80000000, 1'b0);

    // Asynchronous reset with the buffer FULL.
    fill_full(8'h50);
    @(negedge clk);
    check("pre_rst.in_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("arst.out_valid", 64'(bus.out_valid), 64'd0);
    check("arst.out_imm", 64'(bus.out_imm), 64'd0);
    check("arst.in_ready", 64'(bus.in_ready), 64'd1);
    check("arst.out_tag", 64'(bus.out_tag), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    xfer("post_rst", 32'hFFF00093, 4'd2, 8'h60, 32'hFFFFFFFF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
# imm_gen_stage

Registered, parametrised immediate generator for the decode stage. It accepts a full 32-bit instruction word plus an immediate-type code over a valid/ready handshake. It produces the sign- or zero-extended XLEN-wide immediate one cycle later through a 2-entry skid buffer. It supports XLEN 32/64, a CSR zimm format, a pass-through tag, flush, and optional RVC compressed immediates.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- TAG_W, 8: width of the side-band tag (PC index, ROB id) carried with each immediate; ≥1.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  synchronous; discards all buffered entries
- in_valid  input  1  upstream holds a valid instruction
- in_ready  output  1  block can accept this cycle
- in_instr  input  32  instruction word (compressed forms in bits [15:0])
- in_imm_type  input  4  immediate format code (see Operation)
- in_tag  input  TAG_W  side-band tag
- out_valid  output  1  out_imm/out_tag/out_illegal valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  extended immediate
- out_tag  output  TAG_W  tag paired with out_imm
- out_illegal  output  1  reserved or disabled format code was used

## Operation
- Format codes; bit positions refer to in_instr. Sign-extend to XLEN unless marked zero.
  - 0: none, imm=0.
  - 1: SHAMT, zero-extended. Source is [24:20] when XLEN=32 and [25:20] when XLEN=64.
  - 2: I, [31:20].
  - 3: S, {[31:25],[11:7]}.
  - 4: B, {[31],[7],[30:25],[11:8],0}.
  - 5: U, {[31:12],12'b0}; sign-extended from bit 31 when XLEN=64.
  - 6: J, {[31],[19:12],[20],[30:21],0}.
  - 7: Z (CSR zimm), [19:15], zero-extended.
  - 8–12: RVC formats (see Configuration).
  - 13–15: reserved; imm=0 and out_illegal=1.
- Extension is combinational on the input side. The result, tag and illegal flag are captured together as one entry.
- Storage is a 2-entry skid buffer: a main output register plus one skid register.
  - in_ready = skid entry empty. This is a registered signal with no combinational path from out_ready.
  - Accept on in_valid & in_ready. Deliver on out_valid & out_ready.
  - Entries leave in acceptance order. No entry is dropped or duplicated.
  - Simultaneous accept and deliver with one entry held: the new entry moves into the main register and the skid register stays empty.
- flush: next cycle out_valid=0 and in_ready=1. Any input presented in the flush cycle is discarded. flush takes priority over accept and deliver.
- States by occupancy:
  - EMPTY (0 entries): accept moves to ONE.
  - ONE (1 entry):
    - accept without deliver moves to FULL.
    - deliver without accept moves to EMPTY.
    - accept with deliver stays in ONE.
  - FULL (2 entries):
    - deliver moves to ONE.
    - accept is blocked while FULL.
  - flush from any state moves to EMPTY.

## Timing
- Latency: 1 cycle from accept to out_valid, when the buffer is empty.
- Throughput: 1 entry per cycle while out_ready=1.
- Reset (async assert, sync release):
  - out_valid=0, in_ready=1, out_imm=0, out_tag=0, out_illegal=0.
  - Occupancy is cleared.
  - Reset during a transfer drops all entries.
- out_imm, out_tag and out_illegal hold stable while out_valid=1 and out_ready=0.
- After FULL, in_ready stays low from the cycle after the second unacknowledged accept until the cycle after the first deliver.

## Configuration
- RVC_EN defined: codes 8–12 decode compressed immediates from in_instr[15:0].
  - 8: CI (c.addi/c.li), sign-extended {[12],[6:2]}.
  - 9: CIW (c.addi4spn), zero-extended {[10:7],[12:11],[5],[6],2'b0}.
  - 10: CL/CS word, zero-extended {[5],[12:10],[6],2'b0}.
  - 11: CJ, sign-extended {[12],[8],[10:9],[6],[7],[2],[11],[5:3],0}.
  - 12: CB branch, sign-extended {[12],[6:5],[2],[11:10],[4:3],0}.
- RVC_EN undefined: codes 8–12 behave as reserved (imm=0, out_illegal=1). No RVC decode logic is synthesised.

## Test plan
- XLEN=32, in_instr=0xFFF00093, type 2, out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_illegal=0.
- in_instr=0xFE000EE3 (beq, −4), type 4 → out_imm=0xFFFFFFFC; XLEN=64 build → 0xFFFFFFFFFFFFFFFC.
- Stream 4 I-type entries (tags 1–4) with out_ready=0 for 3 cycles, then out_ready=1:
  - in_ready drops after tags 1 and 2 are accepted.
  - Outputs appear in order 1, 2, 3, 4, with no loss.
- Buffer FULL, assert flush with in_valid=1 → next cycle out_valid=0, in_ready=1; flushed entries and the flush-cycle input never appear.
- in_instr=0x000010FD (c.addi x1,−1), type 8:
  - RVC_EN defined → out_imm=0xFFFFFFFF, out_illegal=0.
  - RVC_EN undefined → out_imm=0, out_illegal=1.
  - Type 14 → out_imm=0, out_illegal=1 in both builds.
- Assert reset mid-stream with the buffer FULL → out_valid=0, out_imm=0 and in_ready=1 immediately, without waiting for a clock edge.
